// File: rtl/cu_pkg.sv
// Shared types and constants for the ctrl_sequencer control unit:
// opcodes, bus select codes, ALU ops, FSM states and decode classes.
package cu_pkg;

  localparam int unsigned LD_W = 11;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_MOV  = 4'h1,
    OP_LDAC = 4'h2,
    OP_STAC = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_JMP  = 4'h8,
    OP_JMPZ = 4'h9,
    OP_HALT = 4'hF
  } opcode_e;

  localparam logic [3:0] BUS_AR = 4'd0;
  localparam logic [3:0] BUS_DR = 4'd1;
  localparam logic [3:0] BUS_R1 = 4'd2;
  localparam logic [3:0] BUS_R2 = 4'd3;
  localparam logic [3:0] BUS_R3 = 4'd4;
  localparam logic [3:0] BUS_RA = 4'd5;
  localparam logic [3:0] BUS_RB = 4'd6;
  localparam logic [3:0] BUS_RC = 4'd7;
  localparam logic [3:0] BUS_AC = 4'd8;
  localparam logic [3:0] BUS_IR = 4'd10;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEMRD,
    ST_MEMRD2,
    ST_MEMWR,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_MOV,
    CLS_ALU,
    CLS_LDAC,
    CLS_STAC,
    CLS_JMP,
    CLS_JMPZ,
    CLS_HALT
  } op_class_e;

  // Code 9 has no register behind it; 11..15 are unassigned.
  function automatic logic reg_code_valid(input logic [3:0] code);
    return (code <= BUS_AC) || (code == BUS_IR);
  endfunction

  function automatic logic [LD_W-1:0] ld_onehot(input logic [3:0] code);
    logic [LD_W-1:0] v;
    v = '0;
    if (reg_code_valid(code)) v = LD_W'(1) << code;
    return v;
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Bus/handshake bundle between ctrl_sequencer (master) and the datapath/memory (slave).
interface ctrl_sequencer_if #(
  parameter int unsigned PC_W = 12
);
  logic [15:0]          ir;
  logic                 z_flag;
  logic                 mem_ack;
  logic [3:0]           bus_sel;
  logic [cu_pkg::LD_W-1:0] ld_en;
  logic                 ir_from_mem;
  logic [2:0]           alu_op;
  logic                 mem_rd;
  logic                 mem_wr;
  logic                 addr_sel;
  logic [PC_W-1:0]      pc;
  logic                 halted;
  logic                 illegal;
  logic                 err;

  modport master (
    input  ir, z_flag, mem_ack,
    output bus_sel, ld_en, ir_from_mem, alu_op, mem_rd, mem_wr, addr_sel,
           pc, halted, illegal, err
  );

  modport slave (
    output ir, z_flag, mem_ack,
    input  bus_sel, ld_en, ir_from_mem, alu_op, mem_rd, mem_wr, addr_sel,
           pc, halted, illegal, err
  );
endinterface

// File: rtl/cu_decode.sv
// Combinational instruction decode: opcode class, register-code validity,
// one-hot destination and ALU op. Illegal instructions decode as NOP.
module cu_decode
  import cu_pkg::*;
(
  input  logic [15:0]     ir,
  output op_class_e       op_class,
  output logic [3:0]      src,
  output logic [LD_W-1:0] dst_onehot,
  output logic [2:0]      alu_op,
  output logic [11:0]     target,
  output logic            illegal
);

  logic [3:0] dst;
  logic       src_ok;
  logic       dst_ok;

  assign src        = ir[11:8];
  assign dst        = ir[7:4];
  assign target     = ir[11:0];
  assign src_ok     = reg_code_valid(src);
  assign dst_ok     = reg_code_valid(dst);
  assign dst_onehot = ld_onehot(dst);

  always_comb begin
    op_class = CLS_NOP;
    alu_op   = ALU_PASS;
    illegal  = 1'b0;
    case (ir[15:12])
      OP_NOP:  op_class = CLS_NOP;
      OP_MOV: begin
        if (src_ok && dst_ok) op_class = CLS_MOV;
        else                  illegal  = 1'b1;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        if (src_ok) begin
          op_class = CLS_ALU;
          case (ir[15:12])
            OP_ADD:  alu_op = ALU_ADD;
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_OR;
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
      OP_LDAC: op_class = CLS_LDAC;
      OP_STAC: op_class = CLS_STAC;
      OP_JMP:  op_class = CLS_JMP;
      OP_JMPZ: op_class = CLS_JMPZ;
      OP_HALT: op_class = CLS_HALT;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute control sequencer: owns the PC and drives bus select,
// register loads and ALU op. Optional memory-wait watchdog: CU_TIMEOUT_EN.
module ctrl_sequencer
  import cu_pkg::*;
#(
  parameter int unsigned PC_W    = 12,
  parameter int unsigned TIMEOUT = 64
) (
  input logic              clk,
  input logic              rst_n,
  ctrl_sequencer_if.master bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            illegal_q, illegal_d;

  logic [3:0]      bus_sel_c;
  logic [LD_W-1:0] ld_en_c;
  logic            ir_from_mem_c;
  logic [2:0]      alu_op_c;
  logic            mem_rd_c;
  logic            mem_wr_c;
  logic            addr_sel_c;
  logic            halted_c;
  logic            fetch_hold;

  op_class_e       dec_class;
  logic [3:0]      dec_src;
  logic [LD_W-1:0] dec_dst_onehot;
  logic [2:0]      dec_alu_op;
  logic [11:0]     dec_target;
  logic            dec_illegal;

  cu_decode u_decode (
    .ir         (bus.ir),
    .op_class   (dec_class),
    .src        (dec_src),
    .dst_onehot (dec_dst_onehot),
    .alu_op     (dec_alu_op),
    .target     (dec_target),
    .illegal    (dec_illegal)
  );

`ifdef CU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic             drop_q, drop_d;

  // After a timeout, FETCH idles one cycle so the dropped request is visible.
  assign fetch_hold = drop_q;
`else
  assign fetch_hold = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    illegal_d     = illegal_q;
    bus_sel_c     = BUS_AR;
    ld_en_c       = '0;
    ir_from_mem_c = 1'b0;
    alu_op_c      = ALU_PASS;
    mem_rd_c      = 1'b0;
    mem_wr_c      = 1'b0;
    addr_sel_c    = 1'b0;
    halted_c      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (!fetch_hold) begin
          mem_rd_c = 1'b1;
          if (bus.mem_ack) begin
            ld_en_c[BUS_IR] = 1'b1;
            ir_from_mem_c   = 1'b1;
            pc_d            = pc_q + PC_W'(1);
            state_d         = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        illegal_d = illegal_q | dec_illegal;
        case (dec_class)
          CLS_LDAC: state_d = ST_MEMRD;
          CLS_STAC: state_d = ST_MEMWR;
          CLS_HALT: state_d = ST_HALT;
          default:  state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (dec_class)
          CLS_MOV: begin
            bus_sel_c = dec_src;
            ld_en_c   = dec_dst_onehot;
          end
          CLS_ALU: begin
            bus_sel_c       = dec_src;
            alu_op_c        = dec_alu_op;
            ld_en_c[BUS_AC] = 1'b1;
          end
          CLS_JMP:  pc_d = PC_W'(dec_target);
          CLS_JMPZ: if (bus.z_flag) pc_d = PC_W'(dec_target);
          default: ;
        endcase
        state_d = ST_FETCH;
      end
      ST_MEMRD: begin
        mem_rd_c   = 1'b1;
        addr_sel_c = 1'b1;
        if (bus.mem_ack) begin
          ld_en_c[BUS_DR] = 1'b1;
          state_d         = ST_MEMRD2;
        end
      end
      ST_MEMRD2: begin
        bus_sel_c       = BUS_DR;
        ld_en_c[BUS_AC] = 1'b1;
        state_d         = ST_FETCH;
      end
      ST_MEMWR: begin
        bus_sel_c  = BUS_AC;
        mem_wr_c   = 1'b1;
        addr_sel_c = 1'b1;
        if (bus.mem_ack) state_d = ST_FETCH;
      end
      ST_HALT: halted_c = 1'b1;
      default: state_d = ST_FETCH;
    endcase

`ifdef CU_TIMEOUT_EN
    err_d      = err_q;
    drop_d     = 1'b0;
    wait_cnt_d = '0;
    if ((mem_rd_c || mem_wr_c) && !bus.mem_ack) begin
      if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d = ST_FETCH;
        err_d   = 1'b1;
        drop_d  = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef CU_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Reset state decodes to FETCH, so gate strobes with rst_n to drop requests at once.
  assign bus.bus_sel     = rst_n ? bus_sel_c     : '0;
  assign bus.ld_en       = rst_n ? ld_en_c       : '0;
  assign bus.ir_from_mem = rst_n ? ir_from_mem_c : 1'b0;
  assign bus.alu_op      = rst_n ? alu_op_c      : '0;
  assign bus.mem_rd      = rst_n ? mem_rd_c      : 1'b0;
  assign bus.mem_wr      = rst_n ? mem_wr_c      : 1'b0;
  assign bus.addr_sel    = rst_n ? addr_sel_c    : 1'b0;
  assign bus.halted      = rst_n ? halted_c      : 1'b0;
  assign bus.pc          = pc_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed vector table, random
// instructions against an instruction-level model, halt/reset/timeout sequences.
module tb_ctrl_sequencer;

  localparam int unsigned PC_W = 12;

  typedef struct {
    logic [15:0] ir;
    bit          z;
    int          fw;
    int          dw;
    int          cyc;
    logic [11:0] pc;
    int          nld;
    logic [10:0] ld;
    logic [3:0]  bs;
    logic [2:0]  op;
    bit          ill;
  } vec_t;

  typedef struct {
    int          cyc;
    int          nld;
    logic [10:0] ld;
    logic [3:0]  bs;
    logic [2:0]  op;
    int          wr;
    bit          wr_bad;
    bit          hung;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_sequencer_if #(.PC_W(PC_W)) bus_if ();

  ctrl_sequencer #(.PC_W(PC_W), .TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] strobes();
    return {bus_if.bus_sel, bus_if.ld_en, bus_if.alu_op, bus_if.mem_rd, bus_if.mem_wr,
            bus_if.addr_sel, bus_if.ir_from_mem, bus_if.halted, bus_if.illegal, bus_if.err};
  endfunction

  // Instruction-level reference: cycle count, resulting pc, last register load.
  function automatic vec_t model(input logic [15:0] i, input bit z, input int fw, input int dw,
                                 input logic [11:0] pc_in, input bit ill_in);
    vec_t v;
    logic [3:0] opc, s, d;
    bit vs, vd;
    opc = i[15:12]; s = i[11:8]; d = i[7:4];
    vs = (s <= 4'd8) || (s == 4'd10);
    vd = (d <= 4'd8) || (d == 4'd10);
    v.ir = i; v.z = z; v.fw = fw; v.dw = dw;
    v.cyc = fw + 3; v.pc = pc_in + 12'd1; v.nld = 0; v.ld = '0; v.bs = '0; v.op = '0;
    v.ill = ill_in;
    case (opc)
      4'h0: ;
      4'h1: if (vs && vd) begin v.nld = 1; v.ld = 11'(1) << d; v.bs = s; end else v.ill = 1'b1;
      4'h4, 4'h5, 4'h6, 4'h7:
        if (vs) begin v.nld = 1; v.ld = 11'h100; v.bs = s; v.op = 3'(opc - 4'd3); end
        else v.ill = 1'b1;
      4'h2: begin v.cyc = fw + 4 + dw; v.nld = 2; v.ld = 11'h100; v.bs = 4'd1; end
      4'h3: v.cyc = fw + 3 + dw;
      4'h8: v.pc = i[11:0];
      4'h9: if (z) v.pc = i[11:0];
      4'hF: v.cyc = fw + 2;
      default: v.ill = 1'b1;
    endcase
    return v;
  endfunction

  // Entered just after a negedge with the DUT in FETCH; returns at the next FETCH (or HALT).
  task automatic run_instr(input logic [15:0] i, input bit z, input int fw, input int dw,
                           output obs_t o);
    int  wcnt;
    bit  fetched;
    o = '{0, 0, '0, '0, '0, 0, 1'b0, 1'b1};
    wcnt = 0; fetched = 1'b0;
    bus_if.ir = i;
    bus_if.z_flag = z;
    for (int k = 0; k < 80; k++) begin
      #1;
      bus_if.mem_ack = 1'b0;
      if ((fetched && bus_if.mem_rd && !bus_if.addr_sel) || bus_if.halted) begin
        o.hung = 1'b0;
        break;
      end
      if (bus_if.mem_rd || bus_if.mem_wr) begin
        bus_if.mem_ack = (wcnt >= (fetched ? dw : fw));
        wcnt = bus_if.mem_ack ? 0 : wcnt + 1;
      end
      #1;
      check("rd_wr_exclusive", {31'd0, bus_if.mem_rd & bus_if.mem_wr}, 32'd0);
      o.cyc++;
      if (bus_if.ld_en[10] && bus_if.ir_from_mem) fetched = 1'b1;
      if (bus_if.ld_en != '0 && !bus_if.ir_from_mem) begin
        o.nld++; o.ld = bus_if.ld_en; o.bs = bus_if.bus_sel; o.op = bus_if.alu_op;
      end
      if (bus_if.mem_wr) begin
        o.wr++;
        if (bus_if.bus_sel != 4'd8 || !bus_if.addr_sel) o.wr_bad = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    obs_t o;
    run_instr(v.ir, v.z, v.fw, v.dw, o);
    check({tag, "_done"}, {31'd0, o.hung}, 32'd0);
    check({tag, "_cycles"}, o.cyc, v.cyc);
    check({tag, "_pc"}, {20'd0, bus_if.pc}, {20'd0, v.pc});
    check({tag, "_nloads"}, o.nld, v.nld);
    check({tag, "_ld_en"}, {21'd0, o.ld}, {21'd0, v.ld});
    if (v.nld > 0) begin
      check({tag, "_bus_sel"}, {28'd0, o.bs}, {28'd0, v.bs});
      check({tag, "_alu_op"}, {29'd0, o.op}, {29'd0, v.op});
    end
    check({tag, "_illegal"}, {31'd0, bus_if.illegal}, {31'd0, v.ill});
    check({tag, "_wr_cycles"}, o.wr, (v.ir[15:12] == 4'h3) ? v.dw + 1 : 0);
    check({tag, "_wr_bus"}, {31'd0, o.wr_bad}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.mem_ack = 1'b0;
    #1;
    check("reset_strobes", {7'd0, strobes()}, 32'd0);
    check("reset_pc", {20'd0, bus_if.pc}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_test(input int n);
    logic [3:0]  ops [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC};
    logic [3:0]  opc;
    logic [15:0] i;
    logic [11:0] mpc;
    bit          mill;
    vec_t        v;
    mpc = '0; mill = 1'b0;
    for (int k = 0; k < n; k++) begin
      opc = ops[$urandom_range(0, 11)];
      case (opc)
        4'h1:                   i = {opc, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'h0};
        4'h4, 4'h5, 4'h6, 4'h7: i = {opc, 4'($urandom_range(0, 15)), 8'h00};
        4'h8, 4'h9, 4'hB, 4'hC: i = {opc, 12'($urandom_range(0, 4095))};
        default:                i = {opc, 12'h000};
      endcase
      v = model(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), mpc, mill);
      apply(v, $sformatf("rnd%0d", k));
      mpc = v.pc;
      mill = v.ill;
    end
  endtask

  task automatic halt_test();
    vec_t v;
    v = '{16'hF000, 1'b0, 0, 0, 2, 12'h001, 0, 11'h000, 4'h0, 3'd0, 1'b0};
    apply(v, "halt");
    check("halt_flag", {31'd0, bus_if.halted}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      bus_if.mem_ack = 1'b1;
      @(negedge clk);
      #1;
      check("halt_no_req", {30'd0, bus_if.mem_rd, bus_if.mem_wr}, 32'd0);
      check("halt_no_load", {21'd0, bus_if.ld_en}, 32'd0);
      check("halt_stays", {31'd0, bus_if.halted}, 32'd1);
      check("halt_pc", {20'd0, bus_if.pc}, 32'h1);
    end
    bus_if.mem_ack = 1'b0;
  endtask

  task automatic reset_mid_memrd();
    bus_if.ir = 16'h2000;
    #1 bus_if.mem_ack = 1'b1;
    @(negedge clk);
    #1 bus_if.mem_ack = 1'b0;
    @(negedge clk);
    #1;
    check("memrd_req", {30'd0, bus_if.mem_rd, bus_if.addr_sel}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {7'd0, strobes()}, 32'd0);
    check("abort_pc", {20'd0, bus_if.pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef CU_TIMEOUT_EN
  task automatic timeout_test();
    int hi;
    hi = 0;
    bus_if.mem_ack = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (!bus_if.mem_rd) break;
      hi++;
      @(negedge clk);
    end
    check("timeout_req_cycles", hi, 64);
    check("timeout_err", {31'd0, bus_if.err}, 32'd1);
    check("timeout_pc", {20'd0, bus_if.pc}, 32'd0);
    @(negedge clk);
    #1;
    check("timeout_refetch", {30'd0, bus_if.mem_rd, bus_if.addr_sel}, 32'd2);
  endtask
`endif

  initial begin
    vec_t tbl[$];
    bus_if.ir = '0;
    bus_if.z_flag = 1'b0;
    bus_if.mem_ack = 1'b0;

    //                ir      z   fw dw cyc pc      nld ld       bs    op    ill
    tbl.push_back('{16'h1280, 0, 0, 0, 3, 12'h001, 1, 11'h100, 4'h2, 3'd0, 1'b0});
    tbl.push_back('{16'h2000, 0, 0, 2, 6, 12'h002, 2, 11'h100, 4'h1, 3'd0, 1'b0});
    tbl.push_back('{16'h4300, 0, 0, 0, 3, 12'h003, 1, 11'h100, 4'h3, 3'd1, 1'b0});
    tbl.push_back('{16'h5700, 0, 1, 0, 4, 12'h004, 1, 11'h100, 4'h7, 3'd2, 1'b0});
    tbl.push_back('{16'h6800, 0, 0, 0, 3, 12'h005, 1, 11'h100, 4'h8, 3'd3, 1'b0});
    tbl.push_back('{16'h7A00, 0, 0, 0, 3, 12'h006, 1, 11'h100, 4'hA, 3'd4, 1'b0});
    tbl.push_back('{16'h1010, 0, 0, 0, 3, 12'h007, 1, 11'h002, 4'h0, 3'd0, 1'b0});
    tbl.push_back('{16'h3000, 0, 0, 1, 4, 12'h008, 0, 11'h000, 4'h0, 3'd0, 1'b0});
    tbl.push_back('{16'h0000, 0, 2, 0, 5, 12'h009, 0, 11'h000, 4'h0, 3'd0, 1'b0});
    tbl.push_back('{16'h9123, 0, 0, 0, 3, 12'h00A, 0, 11'h000, 4'h0, 3'd0, 1'b0});
    tbl.push_back('{16'h9123, 1, 0, 0, 3, 12'h123, 0, 11'h000, 4'h0, 3'd0, 1'b0});
    tbl.push_back('{16'h8FFF, 0, 0, 0, 3, 12'hFFF, 0, 11'h000, 4'h0, 3'd0, 1'b0});
    tbl.push_back('{16'h0000, 0, 0, 0, 3, 12'h000, 0, 11'h000, 4'h0, 3'd0, 1'b0});
    tbl.push_back('{16'h1290, 0, 0, 0, 3, 12'h001, 0, 11'h000, 4'h0, 3'd0, 1'b1});
    tbl.push_back('{16'h1AA0, 0, 0, 0, 3, 12'h002, 1, 11'h400, 4'hA, 3'd0, 1'b1});
    tbl.push_back('{16'h4900, 0, 0, 0, 3, 12'h003, 0, 11'h000, 4'h0, 3'd0, 1'b1});
    tbl.push_back('{16'hB000, 0, 0, 0, 3, 12'h004, 0, 11'h000, 4'h0, 3'd0, 1'b1});

    do_reset();
    foreach (tbl[k]) apply(tbl[k], $sformatf("vec%0d", k));

    do_reset();
    random_test(40);

    do_reset();
    halt_test();

    do_reset();
    reset_mid_memrd();

`ifdef CU_TIMEOUT_EN
    do_reset();
    timeout_test();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
